// File: rtl/bsg_fifo_word_packetizer.sv
// bsg_fifo_word_packetizer
//   Width adapter between the 32-bit host FIFO slots and the wide packet
//   interface of the manycore endpoint. One instance per slot; the TX and
//   RX paths share only the clock and reset.
//   TX: packs words_lp consecutive host words into one packet (word 0 = LSB).
//   RX: splits each endpoint packet into words_lp host words, LSB word first.
// Ports
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   word_v_i/word_data_i/word_ready_o   TX word input handshake
//   pkt_v_o/pkt_data_o/pkt_ready_i      assembled packet output handshake
//   pkt_v_i/pkt_data_i/pkt_ready_o      RX packet input handshake
//   word_v_o/word_data_o/word_ready_i   RX word output handshake
//   asm_cnt_o                      words held in the partial TX packet
// All valid/ready outputs decode from registered state only.
module bsg_fifo_word_packetizer #(
   parameter  int packet_width_p = 128,
   localparam int words_lp       = packet_width_p / 32,
   localparam int cnt_width_lp   = (words_lp > 1) ? $clog2(words_lp) : 1
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   // TX word side
   input  logic                      word_v_i,
   input  logic [31:0]               word_data_i,
   output logic                      word_ready_o,
   // TX packet side
   output logic                      pkt_v_o,
   output logic [packet_width_p-1:0] pkt_data_o,
   input  logic                      pkt_ready_i,
   // RX packet side
   input  logic                      pkt_v_i,
   input  logic [packet_width_p-1:0] pkt_data_i,
   output logic                      pkt_ready_o,
   // RX word side
   output logic                      word_v_o,
   output logic [31:0]               word_data_o,
   input  logic                      word_ready_i,
   // status
   output logic [cnt_width_lp-1:0]   asm_cnt_o
);

   localparam logic [cnt_width_lp-1:0] last_idx_lp = cnt_width_lp'(words_lp - 1);

   typedef enum logic {TX_FILL, TX_SEND} tx_state_e;
   typedef enum logic {RX_IDLE, RX_DRAIN} rx_state_e;

   // ---------------------------------------------------------------- TX path
   tx_state_e                 tx_state_r, tx_state_n;
   logic [cnt_width_lp-1:0]   asm_cnt_r, asm_cnt_n;
   logic [packet_width_p-1:0] tx_pkt_r;
   logic                      word_accept;

   always_comb begin
      tx_state_n  = tx_state_r;
      asm_cnt_n   = asm_cnt_r;
      word_accept = 1'b0;
      case (tx_state_r)
         TX_FILL: begin
            if (word_v_i) begin
               word_accept = 1'b1;
               if (asm_cnt_r == last_idx_lp) begin
                  asm_cnt_n  = '0;
                  tx_state_n = TX_SEND;
               end else begin
                  asm_cnt_n = asm_cnt_r + 1'b1;
               end
            end
         end
         TX_SEND: begin
            if (pkt_ready_i) tx_state_n = TX_FILL;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tx_state_r <= TX_FILL;
         asm_cnt_r  <= '0;
         tx_pkt_r   <= '0;
      end else begin
         tx_state_r <= tx_state_n;
         asm_cnt_r  <= asm_cnt_n;
         if (word_accept) tx_pkt_r[32*asm_cnt_r +: 32] <= word_data_i;
      end
   end

   assign word_ready_o = (tx_state_r == TX_FILL);
   assign pkt_v_o      = (tx_state_r == TX_SEND);
   assign pkt_data_o   = tx_pkt_r;
   assign asm_cnt_o    = asm_cnt_r;

   // ---------------------------------------------------------------- RX path
   rx_state_e                 rx_state_r, rx_state_n;
   logic [cnt_width_lp-1:0]   idx_r, idx_n;
   logic [packet_width_p-1:0] rx_pkt_r;
   logic                      pkt_accept;

   always_comb begin
      rx_state_n = rx_state_r;
      idx_n      = idx_r;
      pkt_accept = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            if (pkt_v_i) begin
               pkt_accept = 1'b1;
               idx_n      = '0;
               rx_state_n = RX_DRAIN;
            end
         end
         RX_DRAIN: begin
            if (word_ready_i) begin
               if (idx_r == last_idx_lp) begin
                  rx_state_n = RX_IDLE;
               end else begin
                  idx_n = idx_r + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rx_state_r <= RX_IDLE;
         idx_r      <= '0;
         rx_pkt_r   <= '0;
      end else begin
         rx_state_r <= rx_state_n;
         idx_r      <= idx_n;
         if (pkt_accept) rx_pkt_r <= pkt_data_i;
      end
   end

   assign pkt_ready_o = (rx_state_r == RX_IDLE);
   assign word_v_o    = (rx_state_r == RX_DRAIN);
   assign word_data_o = rx_pkt_r[32*idx_r +: 32];

endmodule
